// File: rtl/tiny86_pkg.sv
// Shared tiny86 definitions: trace step geometry, field widths and the loader state encoding.
package tiny86_pkg;

  localparam int STEP_W  = 560;
  localparam int IN_W    = 32;
  localparam int CNT_W   = 32;
  localparam int INSTR_W = 96;
  localparam int REGS_W  = 320;
  localparam int HINT_W  = 72;
  localparam int NWORDS  = (STEP_W + IN_W - 1) / IN_W;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    DONE = 2'd2
  } loader_state_e;

endpackage

// File: rtl/trace_step_loader_step_out_reg.sv
// Output holding register for one trace step: valid/ready handshake plus a wrapping count of handed-off steps.
module step_out_reg
  import tiny86_pkg::*;
#(
  parameter int STEP_W = tiny86_pkg::STEP_W,
  parameter int CNT_W  = tiny86_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [STEP_W-1:0] load_data,
  input  logic              step_ready,
  output logic [STEP_W-1:0] step,
  output logic              step_valid,
  output logic [CNT_W-1:0]  step_count
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              xfer;

  // A load in the same cycle as a consume overrides the valid clear, so there is no gap.
  always_comb begin
    xfer    = valid_q && step_ready;
    step_d  = step_q;
    valid_d = valid_q;
    count_d = count_q;
    if (xfer) begin
      valid_d = 1'b0;
      count_d = count_q + CNT_W'(1);
    end
    if (load) begin
      step_d  = load_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      step_q  <= step_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign step       = step_q;
  assign step_valid = valid_q;
  assign step_count = count_q;

endmodule

// File: rtl/trace_step_loader.sv
// Deserialises IN_W-bit witness words into STEP_W-bit tiny86 trace steps, double-buffered against the output register.
module trace_step_loader
  import tiny86_pkg::*;
#(
  parameter int STEP_W = tiny86_pkg::STEP_W,
  parameter int IN_W   = tiny86_pkg::IN_W,
  parameter int CNT_W  = tiny86_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_last,
  output logic [STEP_W-1:0] step,
  output logic              step_valid,
  input  logic              step_ready,
  output logic [CNT_W-1:0]  step_count,
  output logic              err_pad,
  output logic              err_frame,
  output logic              trace_done
);

  localparam int NWORDS    = (STEP_W + IN_W - 1) / IN_W;
  localparam int IDX_W     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BUF_W     = NWORDS * IN_W;
  localparam int LAST_BITS = STEP_W - (NWORDS - 1) * IN_W;
  localparam logic [IN_W-1:0]  KEEP_MASK = {IN_W{1'b1}} >> (IN_W - LAST_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NWORDS - 1);

  loader_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BUF_W-1:0]  asm_q, asm_d;
  logic              last_q, last_d;
  logic              err_pad_q, err_pad_d;
  logic              err_frame_q, err_frame_d;
  logic              accept;
  logic              final_word;
  logic              out_free;
  logic              load;
  logic [IN_W-1:0]   word;
  logic              step_valid_int;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    last_d      = last_q;
    err_pad_d   = err_pad_q;
    err_frame_d = err_frame_q;
    load        = 1'b0;
    accept      = in_valid && (state_q == FILL);
    final_word  = (idx_q == LAST_IDX);
    out_free    = !step_valid_int || step_ready;
    // Padding is masked off here so the buffer's spare top bits always stay zero.
    word        = final_word ? (in_data & KEEP_MASK) : in_data;

    if (accept) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (idx_q == IDX_W'(k)) asm_d[k*IN_W +: IN_W] = word;
      end
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          if (final_word) begin
            idx_d = '0;
            if (|(in_data & ~KEEP_MASK)) err_pad_d = 1'b1;
            if (out_free) begin
              load = 1'b1;
              if (in_last) state_d = DONE;
            end else begin
              state_d = FULL;
              last_d  = in_last;
            end
          end else if (in_last) begin
            err_frame_d = 1'b1;
            idx_d       = '0;
            state_d     = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      FULL: begin
        // The completed step waits in asm until the output register is consumed.
        if (step_valid_int && step_ready) begin
          load    = 1'b1;
          state_d = last_q ? DONE : FILL;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      asm_q       <= '0;
      last_q      <= 1'b0;
      err_pad_q   <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      last_q      <= last_d;
      err_pad_q   <= err_pad_d;
      err_frame_q <= err_frame_d;
    end
  end

  step_out_reg #(
    .STEP_W (STEP_W),
    .CNT_W  (CNT_W)
  ) u_step_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_data  (asm_d[STEP_W-1:0]),
    .step_ready (step_ready),
    .step       (step),
    .step_valid (step_valid_int),
    .step_count (step_count)
  );

  assign step_valid = step_valid_int;
  assign in_ready   = (state_q == FILL);
  assign err_pad    = err_pad_q;
  assign err_frame  = err_frame_q;
  assign trace_done = (state_q == DONE) && !step_valid_int;

endmodule
